// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing, colour and sprite constants for the dog renderer
//
// Purpose : timing description type, 640x480@60 defaults, derived totals and
//           sync window helpers, colour/ROM widths, sprite geometry and colours.
// Ports   : none (package)
package vga_pkg;

   localparam int CNT_W    = 11;   // wide enough for h/v counters and hit-test sums
   localparam int COLOR_W  = 12;
   localparam int ROM_AW   = 15;
   localparam int SPR_W    = 64;
   localparam int SPR_H    = 64;
   localparam int SPR_BITS = 6;    // log2 of sprite width/height

   localparam logic [COLOR_W-1:0] TRANSP   = 12'hF0F;
   localparam logic [COLOR_W-1:0] BG_COLOR = 12'h4A4;

   typedef struct packed {
      logic [CNT_W-1:0] h_active;
      logic [CNT_W-1:0] h_fp;
      logic [CNT_W-1:0] h_sync;
      logic [CNT_W-1:0] h_bp;
      logic [CNT_W-1:0] v_active;
      logic [CNT_W-1:0] v_fp;
      logic [CNT_W-1:0] v_sync;
      logic [CNT_W-1:0] v_bp;
   } vga_timing_t;

   function automatic vga_timing_t make_timing(input int ha, input int hfp, input int hs,
                                               input int hbp, input int va, input int vfp,
                                               input int vs, input int vbp);
      vga_timing_t t;
      t.h_active = 11'(ha);
      t.h_fp     = 11'(hfp);
      t.h_sync   = 11'(hs);
      t.h_bp     = 11'(hbp);
      t.v_active = 11'(va);
      t.v_fp     = 11'(vfp);
      t.v_sync   = 11'(vs);
      t.v_bp     = 11'(vbp);
      return t;
   endfunction

   function automatic int h_total(input vga_timing_t t);
      return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
   endfunction

   function automatic int v_total(input vga_timing_t t);
      return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
   endfunction

   function automatic int h_sync_start(input vga_timing_t t);
      return int'(t.h_active) + int'(t.h_fp);
   endfunction

   function automatic int v_sync_start(input vga_timing_t t);
      return int'(t.v_active) + int'(t.v_fp);
   endfunction

   localparam vga_timing_t VGA_640X480 = make_timing(640, 16, 96, 48, 480, 10, 2, 33);

   localparam int H_TOTAL      = h_total(VGA_640X480);                        // 800
   localparam int V_TOTAL      = v_total(VGA_640X480);                        // 525
   localparam int H_SYNC_START = h_sync_start(VGA_640X480);                   // 656
   localparam int H_SYNC_END   = H_SYNC_START + int'(VGA_640X480.h_sync);     // 752, exclusive
   localparam int V_SYNC_START = v_sync_start(VGA_640X480);                   // 490
   localparam int V_SYNC_END   = V_SYNC_START + int'(VGA_640X480.v_sync);     // 492, exclusive

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster counters, active window, raw syncs and frame tick
//
// Purpose : free-running h/v counters plus stage-0 decodes taken straight
//           from the counter values.
// Ports   : pixel_clk  - pixel clock
//           reset      - asynchronous active-low reset
//           h_cnt      - horizontal position 0..H_TOTAL-1
//           v_cnt      - vertical position 0..V_TOTAL-1
//           active     - inside the visible area
//           hsync_raw  - active-low hsync, undelayed
//           vsync_raw  - active-low vsync, undelayed
//           frame_tick - high for the single clock at (0, V_ACTIVE)
module vga_timing
   import vga_pkg::*;
#(
   parameter vga_timing_t TIMING = VGA_640X480
) (
   input  logic             pixel_clk,
   input  logic             reset,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             active,
   output logic             hsync_raw,
   output logic             vsync_raw,
   output logic             frame_tick
);

   localparam int HT  = h_total(TIMING);
   localparam int VT  = v_total(TIMING);
   localparam int HA  = int'(TIMING.h_active);
   localparam int VA  = int'(TIMING.v_active);
   localparam int HS0 = h_sync_start(TIMING);
   localparam int HS1 = HS0 + int'(TIMING.h_sync);
   localparam int VS0 = v_sync_start(TIMING);
   localparam int VS1 = VS0 + int'(TIMING.v_sync);

   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == CNT_W'(HT - 1)) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == CNT_W'(VT - 1)) ? '0 : v_cnt + CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + CNT_W'(1);
      end
   end

   assign active     = (h_cnt < CNT_W'(HA)) && (v_cnt < CNT_W'(VA));
   assign hsync_raw  = !((h_cnt >= CNT_W'(HS0)) && (h_cnt < CNT_W'(HS1)));
   assign vsync_raw  = !((v_cnt >= CNT_W'(VS0)) && (v_cnt < CNT_W'(VS1)));
   // First clock of vertical blanking; the renderer snapshots its inputs here.
   assign frame_tick = (h_cnt == '0) && (v_cnt == CNT_W'(VA));

endmodule

// File: rtl/dog_sprite_render.sv
// rtl/dog_sprite_render.sv - composites the dog sprite over a flat background on VGA
//
// Purpose : snapshots the action state once per frame, hit-tests every pixel
//           against the sprite box, addresses the external sprite ROM and
//           outputs 12-bit RGB with syncs, all 3 clocks behind the counters.
// Ports   : pixel_clk  - pixel clock, the only clock
//           reset      - asynchronous active-low reset
//           ActionSel  - sprite frame index from action
//           DogPos_x   - sprite top-left x
//           DogPos_y   - sprite top-left y
//           rom_addr   - {frame, sy, sx} sprite ROM address
//           rom_data   - ROM colour, valid one clock after rom_addr
//           frame_tick - one-clock pulse at start of vertical blanking
//           hsync      - active-low hsync, pixel aligned
//           vsync      - active-low vsync, pixel aligned
//           rgb        - {R,G,B} 4 bits each, 0 outside active area
module dog_sprite_render
   import vga_pkg::*;
#(
   parameter vga_timing_t TIMING = VGA_640X480
) (
   input  logic               pixel_clk,
   input  logic               reset,
   input  logic [2:0]         ActionSel,
   input  logic [9:0]         DogPos_x,
   input  logic [8:0]         DogPos_y,
   output logic [ROM_AW-1:0]  rom_addr,
   input  logic [COLOR_W-1:0] rom_data,
   output logic               frame_tick,
   output logic               hsync,
   output logic               vsync,
   output logic [COLOR_W-1:0] rgb
);

   logic [CNT_W-1:0]    h_cnt;
   logic [CNT_W-1:0]    v_cnt;
   logic                active0;
   logic                hs0;
   logic                vs0;

   logic [2:0]          act_q;
   logic [9:0]          x_q;
   logic [8:0]          y_q;

   logic [CNT_W-1:0]    x_ext;
   logic [CNT_W-1:0]    y_ext;
   logic [CNT_W-1:0]    x_end;
   logic [CNT_W-1:0]    y_end;
   logic                in_spr0;
   logic [SPR_BITS-1:0] dx;
   logic [SPR_BITS-1:0] dy;

   logic                active1, in_spr1, hs1, vs1;
   logic                active2, in_spr2, hs2, vs2;

   vga_timing #(.TIMING(TIMING)) u_timing (
      .pixel_clk  (pixel_clk),
      .reset      (reset),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .active     (active0),
      .hsync_raw  (hs0),
      .vsync_raw  (vs0),
      .frame_tick (frame_tick)
   );

   // Snapshot only in blanking so the whole visible frame uses one state.
   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         act_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
      end else if (frame_tick) begin
         act_q <= ActionSel;
         x_q   <= DogPos_x;
         y_q   <= DogPos_y;
      end
   end

   // 11-bit sums cannot overflow, so boxes past the right/bottom edge clip
   // naturally against the active window instead of wrapping.
   assign x_ext   = {1'b0, x_q};
   assign y_ext   = {2'b0, y_q};
   assign x_end   = x_ext + CNT_W'(SPR_W);
   assign y_end   = y_ext + CNT_W'(SPR_H);
   assign in_spr0 = active0 && (h_cnt >= x_ext) && (h_cnt < x_end) &&
                    (v_cnt >= y_ext) && (v_cnt < y_end);
   assign dx      = SPR_BITS'(h_cnt - x_ext);
   assign dy      = SPR_BITS'(v_cnt - y_ext);

   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         rom_addr <= '0;
         active1  <= 1'b0;
         in_spr1  <= 1'b0;
         hs1      <= 1'b1;
         vs1      <= 1'b1;
         active2  <= 1'b0;
         in_spr2  <= 1'b0;
         hs2      <= 1'b1;
         vs2      <= 1'b1;
         rgb      <= '0;
         hsync    <= 1'b1;
         vsync    <= 1'b1;
      end else begin
         // Stage 1: ROM address; it holds outside the sprite to avoid needless toggling.
         if (in_spr0) begin
            rom_addr <= {act_q, dy, dx};
         end
         active1 <= active0;
         in_spr1 <= in_spr0;
         hs1     <= hs0;
         vs1     <= vs0;
         // Stage 2: ROM word for this pixel is arriving on rom_data.
         active2 <= active1;
         in_spr2 <= in_spr1;
         hs2     <= hs1;
         vs2     <= vs1;
         // Stage 3: output register.
         if (!active2) begin
            rgb <= '0;
         end else if (in_spr2 && (rom_data != TRANSP)) begin
            rgb <= rom_data;
         end else begin
            rgb <= BG_COLOR;
         end
         hsync <= hs2;
         vsync <= vs2;
      end
   end

endmodule

// File: tb/tb_dog_sprite_render.sv
// tb/tb_dog_sprite_render.sv - scoreboard bench for dog_sprite_render on a reduced raster
module tb_dog_sprite_render;
   import vga_pkg::*;

   localparam int HA = 128, HFP = 8, HS = 16, HBP = 8;
   localparam int VA = 80,  VFP = 4, VS = 2,  VBP = 4;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
   localparam vga_timing_t TB_T = make_timing(HA, HFP, HS, HBP, VA, VFP, VS, VBP);

   logic        pixel_clk = 1'b0;
   logic        reset;
   logic [2:0]  ActionSel;
   logic [9:0]  DogPos_x;
   logic [8:0]  DogPos_y;
   logic [14:0] rom_addr;
   logic [11:0] rom_data;
   logic        frame_tick;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb;

   always #5 pixel_clk = ~pixel_clk;

   dog_sprite_render #(.TIMING(TB_T)) dut (
      .pixel_clk  (pixel_clk),
      .reset      (reset),
      .ActionSel  (ActionSel),
      .DogPos_x   (DogPos_x),
      .DogPos_y   (DogPos_y),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .frame_tick (frame_tick),
      .hsync      (hsync),
      .vsync      (vsync),
      .rgb        (rgb)
   );

   logic [11:0] rom_mem [0:32767];
   always @(posedge pixel_clk) rom_data <= rom_mem[rom_addr];

   typedef struct packed {
      logic [11:0] col;
      logic        hs;
      logic        vs;
   } pix_t;

   pix_t        pix_q[$];
   logic [14:0] addr_q[$];
   logic        tick_q[$];

   int          n_tests = 0;
   int          n_fail = 0;
   int          p;
   logic [2:0]  la;
   int          lx, ly;
   logic [14:0] last_addr;
   bit          running = 1'b0;
   int          cyc;
   int          last_tick;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected behaviour of pixel number p since reset release, from raster rules.
   task automatic model_step();
      int          h, v;
      bit          act, ins;
      logic [14:0] a;
      logic [11:0] w;
      pix_t        e;
      bit          tick;
      h = p % HT;
      v = (p / HT) % VT;
      act = (h < HA) && (v < VA);
      ins = act && (h >= lx) && (h < lx + 64) && (v >= ly) && (v < ly + 64);
      e.col = 12'h000;
      if (act) e.col = 12'h4A4;
      if (ins) begin
         a = {la, 6'(v - ly), 6'(h - lx)};
         w = rom_mem[a];
         if (w != 12'hF0F) e.col = w;
         last_addr = a;
      end
      e.hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
      e.vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
      tick = (h == 0) && (v == VA);
      pix_q.push_back(e);
      addr_q.push_back(last_addr);
      tick_q.push_back(tick);
      if (tick) begin
         la = ActionSel;
         lx = int'(DogPos_x);
         ly = int'(DogPos_y);
      end
      p++;
   endtask

   always @(posedge pixel_clk) begin
      if (running) begin
         #2;
         if (running) model_step();
      end
   end

   always @(negedge pixel_clk) begin
      if (running) begin
         if (pix_q.size() == 0 || addr_q.size() == 0 || tick_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_underflow: got empty queue expected entry at t=%0t", $time);
         end else begin
            pix_t e;
            e = pix_q.pop_front();
            check("rgb", 32'(rgb), 32'(e.col));
            check("hsync", 32'(hsync), 32'(e.hs));
            check("vsync", 32'(vsync), 32'(e.vs));
            check("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
            check("frame_tick", 32'(frame_tick), 32'(tick_q.pop_front()));
         end
         cyc++;
         if (frame_tick === 1'b1) begin
            if (last_tick >= 0) check("tick_period", cyc - last_tick, FRAME);
            last_tick = cyc;
         end
      end
   end

   task automatic check_reset_outputs();
      check("reset_rgb", 32'(rgb), 0);
      check("reset_hsync", 32'(hsync), 1);
      check("reset_vsync", 32'(vsync), 1);
      check("reset_rom_addr", 32'(rom_addr), 0);
      check("reset_frame_tick", 32'(frame_tick), 0);
   endtask

   // Called just after a rising edge; releases reset and starts the model at pixel 0.
   task automatic start_run();
      pix_t z;
      reset = 1'b1;
      p = 0;
      la = 3'd0;
      lx = 0;
      ly = 0;
      last_addr = 15'd0;
      pix_q.delete();
      addr_q.delete();
      tick_q.delete();
      z.col = 12'h000;
      z.hs = 1'b1;
      z.vs = 1'b1;
      repeat (3) pix_q.push_back(z);
      addr_q.push_back(15'd0);
      cyc = -1;
      last_tick = -1;
      running = 1'b1;
      model_step();
   endtask

   task automatic measure_hsync();
      int c, w;
      c = 0;
      w = 0;
      @(negedge pixel_clk);
      while (hsync !== 1'b0 && c < 2 * HT) begin
         @(negedge pixel_clk);
         c++;
      end
      check("hsync_fall_cycle", c, 3 + HA + HFP);
      while (hsync === 1'b0 && w < 2 * HT) begin
         @(negedge pixel_clk);
         w++;
      end
      check("hsync_low_width", w, HS);
   endtask

   task automatic wait_p(input int target);
      int guard;
      guard = 0;
      while (p < target && guard < 4 * FRAME) begin
         @(posedge pixel_clk);
         guard++;
      end
      if (p < target) begin
         $display("FAIL wait_p: got pixel %0d expected %0d", p, target);
         $fatal(1, "wait bound expired");
      end
      #1;
   endtask

   initial begin
      reset = 1'b0;
      ActionSel = 3'd0;
      DogPos_x = 10'd0;
      DogPos_y = 9'd0;
      for (int i = 0; i < 32768; i++) begin
         rom_mem[i] = ($urandom_range(0, 7) == 0) ? 12'hF0F : 12'($urandom);
      end

      repeat (5) @(posedge pixel_clk);
      #1;
      check_reset_outputs();

      // Frame 0 draws frame 0 at (0,0); frame 1 picks up 3/(20,30).
      ActionSel = 3'd3;
      DogPos_x = 10'd20;
      DogPos_y = 9'd30;
      start_run();
      measure_hsync();

      // Change mid frame 1: must not appear until frame 2 (clipped right and bottom).
      wait_p(FRAME + 40 * HT);
      ActionSel = 3'd5;
      DogPos_x = 10'd100;
      DogPos_y = 9'd60;

      // Inputs churn every clock through frame 2; only the tick value matters.
      wait_p(2 * FRAME);
      while (p < 3 * FRAME) begin
         ActionSel = 3'($urandom);
         DogPos_x = 10'($urandom_range(0, HA - 1));
         DogPos_y = 9'($urandom_range(0, VA - 1));
         @(posedge pixel_clk);
         #1;
      end

      // Asynchronous reset in the middle of frame 3's active area.
      wait_p(3 * FRAME + 60 * HT);
      @(posedge pixel_clk);
      #3;
      reset = 1'b0;
      running = 1'b0;
      #1;
      check_reset_outputs();
      repeat (3) @(posedge pixel_clk);
      #1;
      check_reset_outputs();
      start_run();
      measure_hsync();
      wait_p(FRAME + 2 * HT);

      running = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
